frame_reader: RTL and testbench
===============================

FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 480: visible lines.
REQ-003 Parameter V_TOTAL, default 525: total lines per frame, including vertical blank.
REQ-004 Clk  input  1: 50 MHz system clock; the only clock.
REQ-005 Reset  input  1: synchronous, active-high reset.
REQ-006 DrawX  input  10: current VGA pixel column, 0..799.
REQ-007 DrawY  input  10: current VGA line, 0..524.
REQ-008 fb_busy  input  1: frame-buffer writer owns the port this cycle (writer's we).
REQ-009 rd_addr  output  20: frame-buffer word read address.
REQ-010 rd_en  output  1: read request this cycle.
REQ-011 rd_data  input  16: frame-buffer word, valid one Clk after the accepted rd_en.
REQ-012 pixel_idx  output  4: palette index for (DrawX, DrawY).
REQ-013 underrun  output  1: sticky flag; a line fetch was not finished before its display began.

Function
REQ-014 Word format: pixel at even x = rd_data[3:0]; pixel at odd x = rd_data[11:8]; all other bits ignored.
REQ-015 Line mapping: 320 words per line; line y, word w at rd_addr = y*320 + w; width 20 bits, no overflow for y<480.
REQ-016 Line buffer: two banks of 320 x 8 bits (two nibbles per word); bank displayed = DrawY[0], bank filled = ~DrawY[0].
REQ-017 New-line event: registered DrawY differs from current DrawY (one-cycle pulse).
REQ-018 On new-line event: target line = DrawY+1, wrapping V_TOTAL-1 to 0; start a fetch only if target < V_ACTIVE.
REQ-019 FSM states: IDLE, FETCH, DRAIN.
REQ-020 IDLE: on a qualifying new-line event, set word counter to 0, go to FETCH.
REQ-021 FETCH: when fb_busy=0, assert rd_en with rd_addr = target*320 + counter, then increment counter.
REQ-022 FETCH: when fb_busy=1, rd_en=0 and the counter holds (stall, no request lost).
REQ-023 FETCH: after the request with counter=319 is issued, go to DRAIN.
REQ-024 Capture: the cycle after each issued request, write the nibbles of rd_data into the fill bank at the requested word index.
REQ-025 DRAIN: one cycle; complete the final capture, then go to IDLE.
REQ-026 New-line event while in FETCH or DRAIN: set underrun=1 and abort to IDLE, then restart for the new target in the next cycle.
REQ-027 Output: pixel_idx for inputs (DrawX, DrawY) appears exactly 2 Clk later (bank read, then output register).
REQ-028 Output when DrawX>=H_ACTIVE or DrawY>=V_ACTIVE: pixel_idx=0.
REQ-029 Line 0 is fetched during DrawY=524 into bank 0; this is legal because line 524 is not visible.
REQ-030 rd_en is never asserted while fb_busy=1.

Reset
REQ-031 On Reset: FSM=IDLE, counter=0, rd_en=0, rd_addr=0, pixel_idx=0, underrun=0, registered DrawY=0.
REQ-032 Reset mid-FETCH: abandon the fetch; line-buffer contents are not cleared; no capture in the cycle after Reset.
REQ-033 underrun is cleared only by Reset.

Structure
REQ-034 Shared package fb_pkg holds H_ACTIVE, V_ACTIVE, V_TOTAL, WORDS_PER_LINE=320, and the reader state enum.
REQ-035 The two-bank line buffer is a sub-module, line_buf_ram: synchronous write, registered read, 1-bit bank select.
REQ-036 The same fb_pkg constants are used by the trail writer, so writer and reader addressing stay consistent.

Verification
REQ-037 Scenario 1: frame buffer preloaded with word k = {4'h0, k[3:0], 4'h0, k[7:4]}; step DrawY 9 -> 10 with fb_busy=0 -> rd_addr 3520..3839 issued on consecutive cycles, then DRAIN, then IDLE.
REQ-038 Scenario 2: fb_busy high for 5 cycles during FETCH at counter 100 -> rd_en low for those cycles, the next request is 100, all 320 words are captured.
REQ-039 Scenario 3: line 11 displayed with DrawX 0..639 -> pixel_idx matches the preloaded nibbles with 2-cycle latency; DrawX=650 -> pixel_idx=0.
REQ-040 Scenario 4: DrawY 524 -> 0 -> line 0 is fetched during 524 into bank 0; no fetch is triggered at DrawY=479 for target 480.
REQ-041 Scenario 5: fb_busy held at 1 for a full line, then a new-line event -> underrun=1 and stays 1 until Reset.
REQ-042 Scenario 6: Reset asserted at counter 50 -> next cycle rd_en=0, FSM=IDLE, underrun=0, pixel_idx=0.

Source files
------------

// File: rtl/fb_pkg.sv
// Frame-buffer geometry and reader state encoding.
// Shared by the trail writer and the frame reader so both address alike.
package fb_pkg;

    localparam int H_ACTIVE       = 640;
    localparam int V_ACTIVE       = 480;
    localparam int V_TOTAL        = 525;
    localparam int WORDS_PER_LINE = 320;
    localparam int WORD_AW        = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } rd_state_e;

endpackage

// File: rtl/line_buf_ram.sv
// Two-bank line buffer: one byte (two pixel nibbles) per frame-buffer word.
// Synchronous write, registered read.
module line_buf_ram
    import fb_pkg::*;
(
    input  logic               Clk,
    input  logic               we,
    input  logic               wr_bank,
    input  logic [WORD_AW-1:0] wr_idx,
    input  logic [7:0]         wr_data,
    input  logic               rd_bank,
    input  logic [WORD_AW-1:0] rd_idx,
    output logic [7:0]         rd_q
);

    logic [7:0] mem [2][WORDS_PER_LINE];

    always_ff @(posedge Clk) begin
        if (we)
            mem[wr_bank][wr_idx] <= wr_data;
        rd_q <= mem[rd_bank][rd_idx];
    end

endmodule

// File: rtl/frame_reader.sv
// Prefetches the next visible line from the frame buffer into a
// ping-pong line buffer and streams palette indices to the VGA path.
module frame_reader #(
    parameter int H_ACTIVE = fb_pkg::H_ACTIVE,
    parameter int V_ACTIVE = fb_pkg::V_ACTIVE,
    parameter int V_TOTAL  = fb_pkg::V_TOTAL
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        fb_busy,
    output logic [19:0] rd_addr,
    output logic        rd_en,
    input  logic [15:0] rd_data,
    output logic [3:0]  pixel_idx,
    output logic        underrun
);

    import fb_pkg::*;

    localparam logic [9:0] H_LIM  = 10'(H_ACTIVE);
    localparam logic [9:0] V_LIM  = 10'(V_ACTIVE);
    localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
    localparam logic [WORD_AW-1:0] LAST_W = WORD_AW'(WORDS_PER_LINE - 1);

    rd_state_e state, state_nxt;

    logic [9:0]         dy_q;
    logic [9:0]         tgt;
    logic [9:0]         next_line;
    logic [WORD_AW-1:0] cnt;
    logic               pend;
    logic               new_line;
    logic               start_ok;

    logic               cap_v;
    logic               cap_bank;
    logic [WORD_AW-1:0] cap_idx;
    logic [7:0]         cap_data;

    logic               blank;
    logic               blank_q;
    logic               odd_q;
    logic [WORD_AW-1:0] lb_idx;
    logic [7:0]         lb_q;
    logic               unused_rd_bits;

    assign new_line  = (dy_q != DrawY);
    assign next_line = (DrawY == Y_LAST) ? 10'd0 : DrawY + 10'd1;
    assign start_ok  = (next_line < V_LIM);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (new_line ? start_ok : pend)
                    state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (new_line)
                    state_nxt = ST_IDLE;
                else if (!fb_busy && cnt == LAST_W)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // A new line while fetching aborts, so no request is issued that cycle.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = 20'(tgt) * 20'(WORDS_PER_LINE) + 20'(cnt);
        if (state == ST_FETCH && !fb_busy && !new_line && !Reset)
            rd_en = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            dy_q     <= '0;
            tgt      <= '0;
            cnt      <= '0;
            pend     <= 1'b0;
            underrun <= 1'b0;
            cap_v    <= 1'b0;
            cap_bank <= 1'b0;
            cap_idx  <= '0;
        end else begin
            state    <= state_nxt;
            dy_q     <= DrawY;
            cap_v    <= rd_en;
            cap_bank <= tgt[0];
            cap_idx  <= cnt;
            if (state == ST_IDLE) begin
                if (new_line) begin
                    tgt  <= next_line;
                    cnt  <= '0;
                    pend <= 1'b0;
                end else if (pend) begin
                    cnt  <= '0;
                    pend <= 1'b0;
                end
            end else if (new_line) begin
                underrun <= 1'b1;
                tgt      <= next_line;
                pend     <= start_ok;
            end else if (rd_en) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Odd-pixel nibble lands in the upper half of the stored byte.
    assign cap_data       = {rd_data[11:8], rd_data[3:0]};
    assign unused_rd_bits = ^{rd_data[15:12], rd_data[7:4]};

    assign blank  = (DrawX >= H_LIM) || (DrawY >= V_LIM);
    assign lb_idx = blank ? '0 : DrawX[WORD_AW:1];

    line_buf_ram u_lb (
        .Clk     (Clk),
        .we      (cap_v),
        .wr_bank (cap_bank),
        .wr_idx  (cap_idx),
        .wr_data (cap_data),
        .rd_bank (DrawY[0]),
        .rd_idx  (lb_idx),
        .rd_q    (lb_q)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            odd_q     <= 1'b0;
            blank_q   <= 1'b1;
            pixel_idx <= '0;
        end else begin
            odd_q     <= DrawX[0];
            blank_q   <= blank;
            pixel_idx <= blank_q ? 4'd0 : (odd_q ? lb_q[7:4] : lb_q[3:0]);
        end
    end

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader: frame-buffer model, pixel vector
// table, and hand-timed fetch/stall/underrun/reset sequences.
module tb_frame_reader;

    import fb_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        fb_busy;
    logic [19:0] rd_addr;
    logic        rd_en;
    logic [15:0] rd_data = '0;
    logic [3:0]  pixel_idx;
    logic        underrun;

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    typedef struct {
        int x;
        int y;
        int pix;
    } vec_t;

    vec_t tbl[14];

    frame_reader dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .fb_busy   (fb_busy),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .pixel_idx (pixel_idx),
        .underrun  (underrun)
    );

    always #10 Clk = ~Clk;

    function automatic logic [15:0] fbw(input logic [19:0] a);
        return {4'h0, a[3:0], 4'h0, a[7:4]};
    endfunction

    function automatic int pix_of(input int y, input int x);
        logic [19:0] a;
        a = 20'(y * 320 + x / 2);
        return x[0] ? int'(a[3:0]) : int'(a[7:4]);
    endfunction

    // Frame-buffer model: word available one clock after the request.
    always @(posedge Clk) begin
        if (rd_en)
            rd_data <= fbw(rd_addr);
        if (rd_en && fb_busy)
            viol <= viol + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic stream_line(input int y, input string name);
        int errs;
        errs = 0;
        for (int k = 0; k < 642; k++) begin
            tick();
            if (k >= 2 && int'(pixel_idx) != pix_of(y, k - 2)) begin
                if (errs == 0)
                    $display("FAIL %s x=%0d: got %0d want %0d",
                             name, k - 2, pixel_idx, pix_of(y, k - 2));
                errs++;
            end
            DrawX = 10'(k);
        end
        chk(name, errs, 0);
    endtask

    task automatic fetch_seq(input int base, input string name);
        int errs;
        errs = 0;
        for (int i = 1; i <= 322; i++) begin
            tick();
            if (i == 1)
                chk({name, "_first"}, int'(rd_addr), base);
            if (i <= 320) begin
                if (!rd_en || rd_addr != 20'(base + i - 1))
                    errs++;
            end else if (rd_en) begin
                errs++;
            end
            if (i == 321)
                chk({name, "_drain"}, int'(dut.state), int'(ST_DRAIN));
            if (i == 322)
                chk({name, "_idle"}, int'(dut.state), int'(ST_IDLE));
        end
        chk({name, "_seq"}, errs, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;
        int ecnt;
        int nreq;
        int found;

        tbl = '{
            '{0, 11, 12},  '{1, 11, 0},    '{2, 11, 12},  '{3, 11, 1},
            '{31, 11, 15}, '{32, 11, 13},  '{100, 11, 15}, '{101, 11, 2},
            '{300, 11, 5}, '{301, 11, 6},  '{638, 11, 15}, '{639, 11, 15},
            '{650, 11, 0}, '{799, 11, 0}
        };

        Reset   = 1'b1;
        fb_busy = 1'b0;
        DrawX   = '0;
        DrawY   = '0;
        repeat (3) tick();
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_pixel", int'(pixel_idx), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_state", int'(dut.state), int'(ST_IDLE));
        Reset = 1'b0;

        // Line 10 into bank 0, then line 11 into bank 1.
        DrawY = 10'd9;
        repeat (330) tick();
        DrawY = 10'd10;
        fetch_seq(3520, "s1");

        // Line 12 fetch with a 5-cycle stall at word 100.
        DrawY = 10'd11;
        ecnt  = 0;
        nreq  = 0;
        errs  = 0;
        for (int j = 1; j <= 335; j++) begin
            tick();
            if (rd_en)
                nreq++;
            if (fb_busy || ecnt >= 320) begin
                if (rd_en)
                    errs++;
            end else begin
                if (!rd_en || rd_addr != 20'(3840 + ecnt))
                    errs++;
                if (j == 106)
                    chk("s2_resume", int'(rd_addr), 3840 + 100);
                ecnt++;
            end
            fb_busy = (j >= 100 && j < 105);
        end
        chk("s2_seq", errs, 0);
        chk("s2_nreq", nreq, 320);

        foreach (tbl[i]) begin
            tick();
            DrawX = 10'(tbl[i].x);
            DrawY = 10'(tbl[i].y);
            tick();
            tick();
            chk($sformatf("tbl_x%0d", tbl[i].x), int'(pixel_idx), tbl[i].pix);
        end

        stream_line(11, "s3_line11");
        DrawY = 10'd12;
        stream_line(12, "s2_line12");
        chk("s3_underrun", int'(underrun), 0);

        // No fetch for target 480; line 0 fetched during 524.
        DrawY = 10'd479;
        nreq  = 0;
        repeat (20) begin
            tick();
            if (rd_en)
                nreq++;
        end
        chk("s4_no480", nreq, 0);
        chk("s4_idle", int'(dut.state), int'(ST_IDLE));
        DrawX = 10'd10;
        DrawY = 10'd524;
        fetch_seq(0, "s4");
        chk("s4_vblank_pix", int'(pixel_idx), 0);
        DrawY = 10'd0;
        stream_line(0, "s4_line0");
        chk("s4_underrun", int'(underrun), 0);

        // A fully stalled line followed by a new line.
        fb_busy = 1'b1;
        DrawX   = 10'd40;
        DrawY   = 10'd1;
        nreq    = 0;
        repeat (800) begin
            tick();
            if (rd_en)
                nreq++;
        end
        chk("s5_stalled", nreq, 0);
        chk("s5_pre_underrun", int'(underrun), 0);
        DrawY = 10'd2;
        tick();
        chk("s5_underrun", int'(underrun), 1);
        chk("s5_abort_idle", int'(dut.state), int'(ST_IDLE));
        chk("s5_abort_rd_en", int'(rd_en), 0);
        fb_busy = 1'b0;
        tick();
        chk("s5_restart_en", int'(rd_en), 1);
        chk("s5_restart_addr", int'(rd_addr), 960);

        found = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (rd_en && rd_addr == 20'd1010) begin
                found = 1;
                break;
            end
        end
        chk("s6_reach50", found, 1);
        chk("s5_sticky", int'(underrun), 1);
        chk("s6_pre_pix", int'(pixel_idx), 1);

        // Reset in the middle of a fetch.
        Reset = 1'b1;
        tick();
        chk("s6_rd_en", int'(rd_en), 0);
        chk("s6_state", int'(dut.state), int'(ST_IDLE));
        chk("s6_underrun", int'(underrun), 0);
        chk("s6_pixel", int'(pixel_idx), 0);
        Reset = 1'b0;
        repeat (3) tick();
        chk("s6_lb_kept", int'(pixel_idx), 1);

        chk("busy_viol", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
